// File: rtl/cpu_trace_pkg.sv
// Shared definitions for the CPU trace tools: parser states, record format
// codes, error bit positions and the ASCII punctuation used by trace lines.
package cpu_trace_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CARET,
    S_TIME,
    S_AT,
    S_PC,
    S_SP1,
    S_DOLLAR,
    S_STAR,
    S_REG,
    S_ADDR,
    S_SP2,
    S_LT,
    S_EQ,
    S_DATA,
    S_DONE
  } state_e;

  localparam logic [1:0] FMT_NONE = 2'b00;
  localparam logic [1:0] FMT_REG  = 2'b01;
  localparam logic [1:0] FMT_MEM  = 2'b10;

  localparam int ERR_PC_RANGE = 0;
  localparam int ERR_PC_ALIGN = 1;
  localparam int ERR_ADDR     = 2;
  localparam int ERR_REG      = 3;

  localparam logic [7:0] CH_CARET  = 8'h5E;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3A;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_LT     = 8'h3C;
  localparam logic [7:0] CH_EQ     = 8'h3D;
  localparam logic [7:0] CH_HASH   = 8'h23;
  localparam logic [7:0] CH_SPACE  = 8'h20;

endpackage

// File: rtl/trace_char_class.sv
// Combinational ASCII classifier: flags decimal and hex digits and returns
// the digit's nibble value. Upper-case hex is accepted only when enabled.
module trace_char_class #(
  parameter bit ALLOW_UPPER = 1'b0
) (
  input  logic [7:0] char_i,
  output logic       is_dec_o,
  output logic       is_hex_o,
  output logic [3:0] nibble_o
);

  // Classify the character; the nibble is only meaningful when is_hex_o is set
  always_comb begin
    is_dec_o = 1'b0;
    is_hex_o = 1'b0;
    nibble_o = 4'd0;
    if (char_i >= 8'h30 && char_i <= 8'h39) begin
      is_dec_o = 1'b1;
      is_hex_o = 1'b1;
      nibble_o = char_i[3:0];
    end else if (char_i >= 8'h61 && char_i <= 8'h66) begin
      is_hex_o = 1'b1;
      nibble_o = char_i[3:0] + 4'd9;
    end else if (ALLOW_UPPER && char_i >= 8'h41 && char_i <= 8'h46) begin
      is_hex_o = 1'b1;
      nibble_o = char_i[3:0] + 4'd9;
    end
  end

endmodule

// File: rtl/cpu_trace_parser.sv
// Streaming parser/checker for CPU trace lines. Consumes one ASCII char per
// valid beat, extracts register-write and memory-write record fields, flags
// semantic problems and counts accepted and faulty records.
module cpu_trace_parser
  import cpu_trace_pkg::*;
#(
  parameter int                      TIME_MAX_DIGITS = 4,
  parameter int                      REG_MAX_DIGITS  = 4,
  parameter int                      HEX_DIGITS      = 8,
  parameter int                      TIME_W          = 16,
  parameter bit                      ALLOW_UPPER     = 1'b0,
  parameter logic [4*HEX_DIGITS-1:0] PC_LO           = 'h0000_3000,
  parameter logic [4*HEX_DIGITS-1:0] PC_HI           = 'h0000_6FFC,
  parameter logic [4*HEX_DIGITS-1:0] ADDR_HI         = 'h0000_2FFC,
  parameter int                      CNT_W           = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    char_valid,
  input  logic [7:0]              char,
  output logic [1:0]              format_type,
  output logic                    rec_valid,
  output logic [TIME_W-1:0]       rec_time,
  output logic [4*HEX_DIGITS-1:0] rec_pc,
  output logic [4:0]              rec_reg,
  output logic [4*HEX_DIGITS-1:0] rec_addr,
  output logic [4*HEX_DIGITS-1:0] rec_data,
  output logic [3:0]              error_code,
  output logic [CNT_W-1:0]        rec_count,
  output logic [CNT_W-1:0]        bad_count,
  output logic [3:0]              state_dbg
);

  localparam int XW  = 4 * HEX_DIGITS;
  localparam int DCW = 8;

  logic       is_dec;
  logic       is_hex;
  logic [3:0] nib;

  trace_char_class #(
    .ALLOW_UPPER(ALLOW_UPPER)
  ) u_class (
    .char_i  (char),
    .is_dec_o(is_dec),
    .is_hex_o(is_hex),
    .nibble_o(nib)
  );

  state_e             state_q, state_d;
  logic [DCW-1:0]     cnt_q, cnt_d;
  logic [TIME_W-1:0]  time_q, time_d;
  logic [XW-1:0]      pc_q, pc_d;
  logic [XW-1:0]      addr_q, addr_d;
  logic [XW-1:0]      data_q, data_d;
  logic [13:0]        reg_q, reg_d;
  logic               mem_q, mem_d;
  logic [1:0]         fmt_q, fmt_d;
  logic               valid_q, valid_d;
  logic [3:0]         err_d;

  logic [TIME_W-1:0]  rec_time_q;
  logic [XW-1:0]      rec_pc_q;
  logic [4:0]         rec_reg_q;
  logic [XW-1:0]      rec_addr_q;
  logic [XW-1:0]      rec_data_q;
  logic [3:0]         err_q;
  logic [CNT_W-1:0]   rec_count_q;
  logic [CNT_W-1:0]   bad_count_q;

  // Next-state and shadow-field update for one consumed character; any
  // character not expected in the current state resynchronises on '^'
  always_comb begin
    state_d = (char == CH_CARET) ? S_CARET : S_IDLE;
    cnt_d   = cnt_q;
    time_d  = time_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    data_d  = data_q;
    reg_d   = reg_q;
    mem_d   = mem_q;
    case (state_q)
      S_CARET: begin
        if (is_dec) begin
          state_d = S_TIME;
          cnt_d   = DCW'(1);
          time_d  = {{(TIME_W-4){1'b0}}, nib};
        end
      end
      S_TIME: begin
        if (is_dec && cnt_q < DCW'(TIME_MAX_DIGITS)) begin
          state_d = S_TIME;
          cnt_d   = cnt_q + DCW'(1);
          time_d  = time_q * TIME_W'(10) + {{(TIME_W-4){1'b0}}, nib};
        end else if (char == CH_AT) begin
          state_d = S_AT;
        end
      end
      S_AT: begin
        if (is_hex) begin
          state_d = S_PC;
          cnt_d   = DCW'(1);
          pc_d    = {{(XW-4){1'b0}}, nib};
        end
      end
      S_PC: begin
        if (is_hex && cnt_q < DCW'(HEX_DIGITS)) begin
          state_d = S_PC;
          cnt_d   = cnt_q + DCW'(1);
          pc_d    = {pc_q[XW-5:0], nib};
        end else if (char == CH_COLON && cnt_q == DCW'(HEX_DIGITS)) begin
          state_d = S_SP1;
        end
      end
      S_SP1: begin
        if (char == CH_SPACE) begin
          state_d = S_SP1;
        end else if (char == CH_DOLLAR) begin
          state_d = S_DOLLAR;
          mem_d   = 1'b0;
        end else if (char == CH_STAR) begin
          state_d = S_STAR;
          mem_d   = 1'b1;
        end
      end
      S_DOLLAR: begin
        if (is_dec) begin
          state_d = S_REG;
          cnt_d   = DCW'(1);
          reg_d   = {10'd0, nib};
        end
      end
      S_REG: begin
        if (is_dec && cnt_q < DCW'(REG_MAX_DIGITS)) begin
          state_d = S_REG;
          cnt_d   = cnt_q + DCW'(1);
          reg_d   = reg_q * 14'd10 + {10'd0, nib};
        end else if (char == CH_SPACE) begin
          state_d = S_SP2;
        end else if (char == CH_LT) begin
          state_d = S_LT;
        end
      end
      S_STAR: begin
        if (is_hex) begin
          state_d = S_ADDR;
          cnt_d   = DCW'(1);
          addr_d  = {{(XW-4){1'b0}}, nib};
        end
      end
      S_ADDR: begin
        if (is_hex && cnt_q < DCW'(HEX_DIGITS)) begin
          state_d = S_ADDR;
          cnt_d   = cnt_q + DCW'(1);
          addr_d  = {addr_q[XW-5:0], nib};
        end else if (char == CH_SPACE && cnt_q == DCW'(HEX_DIGITS)) begin
          state_d = S_SP2;
        end else if (char == CH_LT && cnt_q == DCW'(HEX_DIGITS)) begin
          state_d = S_LT;
        end
      end
      S_SP2: begin
        if (char == CH_SPACE) begin
          state_d = S_SP2;
        end else if (char == CH_LT) begin
          state_d = S_LT;
        end
      end
      S_LT: begin
        if (char == CH_EQ) begin
          state_d = S_EQ;
        end
      end
      S_EQ: begin
        if (char == CH_SPACE) begin
          state_d = S_EQ;
        end else if (is_hex) begin
          state_d = S_DATA;
          cnt_d   = DCW'(1);
          data_d  = {{(XW-4){1'b0}}, nib};
        end
      end
      S_DATA: begin
        if (is_hex && cnt_q < DCW'(HEX_DIGITS)) begin
          state_d = S_DATA;
          cnt_d   = cnt_q + DCW'(1);
          data_d  = {data_q[XW-5:0], nib};
        end else if (char == CH_HASH && cnt_q == DCW'(HEX_DIGITS)) begin
          state_d = S_DONE;
        end
      end
      default: ;
    endcase
    // A new record starts from clean shadows so a register record never
    // reports the address of an earlier memory record, and vice versa
    if (state_d == S_CARET) begin
      cnt_d  = '0;
      time_d = '0;
      pc_d   = '0;
      addr_d = '0;
      data_d = '0;
      reg_d  = '0;
      mem_d  = 1'b0;
    end
  end

  // Semantic checks on the completed shadow fields and the format decode
  // that becomes visible once the record reaches DONE
  always_comb begin
    err_d               = '0;
    err_d[ERR_PC_RANGE] = (pc_q < PC_LO) || (pc_q > PC_HI);
    err_d[ERR_PC_ALIGN] = (pc_q[1:0] != 2'b00);
    err_d[ERR_ADDR]     = mem_q && ((addr_q > ADDR_HI) || (addr_q[1:0] != 2'b00));
    err_d[ERR_REG]      = !mem_q && (reg_q > 14'd31);
    valid_d             = (state_d == S_DONE);
    fmt_d               = FMT_NONE;
    if (state_d == S_DONE) begin
      fmt_d = mem_q ? FMT_MEM : FMT_REG;
    end
  end

  // Parser state, shadows, published record and counters; nothing moves
  // unless a character is presented
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      time_q      <= '0;
      pc_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      reg_q       <= '0;
      mem_q       <= 1'b0;
      fmt_q       <= FMT_NONE;
      valid_q     <= 1'b0;
      rec_time_q  <= '0;
      rec_pc_q    <= '0;
      rec_reg_q   <= '0;
      rec_addr_q  <= '0;
      rec_data_q  <= '0;
      err_q       <= '0;
      rec_count_q <= '0;
      bad_count_q <= '0;
    end else if (char_valid) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      time_q  <= time_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      reg_q   <= reg_d;
      mem_q   <= mem_d;
      fmt_q   <= fmt_d;
      valid_q <= valid_d;
      if (state_d == S_DONE) begin
        rec_time_q <= time_q;
        rec_pc_q   <= pc_q;
        rec_reg_q  <= reg_q[4:0];
        rec_addr_q <= addr_q;
        rec_data_q <= data_q;
        err_q      <= err_d;
        if (rec_count_q != {CNT_W{1'b1}}) begin
          rec_count_q <= rec_count_q + CNT_W'(1);
        end
        if (err_d != 4'd0 && bad_count_q != {CNT_W{1'b1}}) begin
          bad_count_q <= bad_count_q + CNT_W'(1);
        end
      end
    end
  end

  assign format_type = fmt_q;
  assign rec_valid   = valid_q;
  assign rec_time    = rec_time_q;
  assign rec_pc      = rec_pc_q;
  assign rec_reg     = rec_reg_q;
  assign rec_addr    = rec_addr_q;
  assign rec_data    = rec_data_q;
  assign error_code  = err_q;
  assign rec_count   = rec_count_q;
  assign bad_count   = bad_count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_cpu_trace_parser.sv
// Self-checking bench for cpu_trace_parser: directed trace lines plus
// randomly built records checked against a field-level reference model.
module tb_cpu_trace_parser;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        char_valid = 1'b0;
  logic [7:0]  char_in = 8'h00;
  logic [1:0]  format_type;
  logic        rec_valid;
  logic [15:0] rec_time;
  logic [31:0] rec_pc;
  logic [4:0]  rec_reg;
  logic [31:0] rec_addr;
  logic [31:0] rec_data;
  logic [3:0]  error_code;
  logic [15:0] rec_count;
  logic [15:0] bad_count;
  logic [3:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int exp_rec = 0;
  int exp_bad = 0;

  cpu_trace_parser dut (
    .clk        (clk),
    .reset      (reset),
    .char_valid (char_valid),
    .char       (char_in),
    .format_type(format_type),
    .rec_valid  (rec_valid),
    .rec_time   (rec_time),
    .rec_pc     (rec_pc),
    .rec_reg    (rec_reg),
    .rec_addr   (rec_addr),
    .rec_data   (rec_data),
    .error_code (error_code),
    .rec_count  (rec_count),
    .bad_count  (bad_count),
    .state_dbg  (state_dbg)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Present one character for exactly one edge, then idle for gap cycles
  task automatic send_char(input logic [7:0] c, input int gap);
    char_in = c;
    char_valid = 1'b1;
    @(posedge clk);
    #1;
    char_valid = 1'b0;
    char_in = 8'h00;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Stream a whole string; fixed_gap>=0 uses that gap, otherwise random 0..1
  task automatic send_line(input string s, input int fixed_gap);
    for (int i = 0; i < s.len(); i++) begin
      send_char(s[i], (fixed_gap >= 0) ? fixed_gap : int'($urandom_range(0, 1)));
    end
  endtask

  function automatic string spaces(input int n);
    string r = "";
    for (int i = 0; i < n; i++) r = {r, " "};
    return r;
  endfunction

  // Reference semantics of a completed record, from plain arithmetic
  function automatic logic [3:0] model_err(input bit is_mem, input longint pc,
                                           input longint addr, input longint regv);
    logic [3:0] e;
    e = 4'd0;
    e[0] = (pc < 'h3000) || (pc > 'h6FFC);
    e[1] = (pc % 4) != 0;
    if (is_mem) e[2] = (addr > 'h2FFC) || ((addr % 4) != 0);
    else        e[3] = (regv > 31);
    return e;
  endfunction

  task automatic model_accept(input logic [3:0] e);
    exp_rec++;
    if (e != 4'd0) exp_bad++;
  endtask

  task automatic test_reset();
    checks++;
    if ({format_type, rec_valid, state_dbg} !== 7'd0) begin
      errors++;
      $display("[TB] FAIL reset_status: got fmt=%0d valid=%0d state=%0d expected all 0", format_type, rec_valid, state_dbg);
    end
    checks++;
    if ({rec_time, rec_pc, rec_reg, rec_addr, rec_data, error_code} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_fields: got time=%0h pc=%0h reg=%0h addr=%0h data=%0h err=%0h expected 0", rec_time, rec_pc, rec_reg, rec_addr, rec_data, error_code);
    end
    checks++;
    if (rec_count !== 16'd0 || bad_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_counts: got rec=%0d bad=%0d expected 0 0", rec_count, bad_count);
    end
  endtask

  task automatic test_reg_record(input int gap, input string tag);
    logic [3:0] e;
    send_line("^10@00003000: $1 <= 0000abcd#", gap);
    e = model_err(1'b0, 'h3000, 0, 1);
    model_accept(e);
    checks++;
    if (format_type !== 2'b01 || rec_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL %s_fmt: got fmt=%0d valid=%0d expected 1 1", tag, format_type, rec_valid);
    end
    checks++;
    if (rec_time !== 16'd10 || rec_pc !== 32'h3000 || rec_reg !== 5'd1 || rec_data !== 32'h0000abcd) begin
      errors++;
      $display("[TB] FAIL %s_fields: got time=%0d pc=%0h reg=%0d data=%0h expected 10 3000 1 abcd", tag, rec_time, rec_pc, rec_reg, rec_data);
    end
    checks++;
    if (error_code !== e || rec_count !== 16'(exp_rec) || bad_count !== 16'(exp_bad)) begin
      errors++;
      $display("[TB] FAIL %s_status: got err=%b rec=%0d bad=%0d expected %b %0d %0d", tag, error_code, rec_count, bad_count, e, exp_rec, exp_bad);
    end
  endtask

  task automatic test_mem_record();
    logic [3:0] e;
    send_line("^1234@00003004: *00000010 <= 12345678#", 0);
    e = model_err(1'b1, 'h3004, 'h10, 0);
    model_accept(e);
    checks++;
    if (format_type !== 2'b10 || rec_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mem_fmt: got fmt=%0d valid=%0d expected 2 1", format_type, rec_valid);
    end
    checks++;
    if (rec_time !== 16'd1234 || rec_pc !== 32'h3004 || rec_addr !== 32'h10 || rec_data !== 32'h12345678) begin
      errors++;
      $display("[TB] FAIL mem_fields: got time=%0d pc=%0h addr=%0h data=%0h expected 1234 3004 10 12345678", rec_time, rec_pc, rec_addr, rec_data);
    end
    checks++;
    if (error_code !== e || rec_count !== 16'(exp_rec)) begin
      errors++;
      $display("[TB] FAIL mem_status: got err=%b rec=%0d expected %b %0d", error_code, rec_count, e, exp_rec);
    end
  endtask

  task automatic test_overflow();
    string lines[3];
    lines[0] = "^12345@00003000: $1 <= 00000000#";
    lines[1] = "^1@0000300: $1 <= 00000000#";
    lines[2] = "^1@0000300A: $1 <= 00000000#";
    foreach (lines[k]) begin
      send_line(lines[k], 0);
      checks++;
      if (format_type !== 2'b00 || rec_valid !== 1'b0 || rec_count !== 16'(exp_rec)) begin
        errors++;
        $display("[TB] FAIL overflow_%0d: got fmt=%0d valid=%0d rec=%0d expected 0 0 %0d", k, format_type, rec_valid, rec_count, exp_rec);
      end
    end
  endtask

  task automatic test_resync();
    logic [3:0] e;
    send_line("^^x^5@00003000:$31<=ffffffff#", 0);
    e = model_err(1'b0, 'h3000, 0, 31);
    model_accept(e);
    checks++;
    if (format_type !== 2'b01 || rec_reg !== 5'd31 || rec_time !== 16'd5 || error_code !== e || rec_count !== 16'(exp_rec)) begin
      errors++;
      $display("[TB] FAIL resync_31: got fmt=%0d reg=%0d time=%0d err=%b rec=%0d expected 1 31 5 %b %0d", format_type, rec_reg, rec_time, error_code, rec_count, e, exp_rec);
    end
    send_line("^5@00003000:$32<=ffffffff#", 0);
    e = model_err(1'b0, 'h3000, 0, 32);
    model_accept(e);
    checks++;
    if (format_type !== 2'b01 || error_code !== e || rec_reg !== 5'd0 || bad_count !== 16'(exp_bad)) begin
      errors++;
      $display("[TB] FAIL resync_32: got fmt=%0d err=%b reg=%0d bad=%0d expected 1 %b 0 %0d", format_type, error_code, rec_reg, bad_count, e, exp_bad);
    end
  endtask

  task automatic test_semantic();
    logic [3:0] e;
    send_line("^7@00003002: $2 <= 00000001#", 0);
    e = model_err(1'b0, 'h3002, 0, 2);
    model_accept(e);
    checks++;
    if (format_type === 2'b00 || error_code !== e || bad_count !== 16'(exp_bad)) begin
      errors++;
      $display("[TB] FAIL sem_pc_align: got fmt=%0d err=%b bad=%0d expected nonzero %b %0d", format_type, error_code, bad_count, e, exp_bad);
    end
    send_line("^8@00003004: *00003000 <= 00000002#", 0);
    e = model_err(1'b1, 'h3004, 'h3000, 0);
    model_accept(e);
    checks++;
    if (format_type !== 2'b10 || error_code !== e || bad_count !== 16'(exp_bad)) begin
      errors++;
      $display("[TB] FAIL sem_addr: got fmt=%0d err=%b bad=%0d expected 2 %b %0d", format_type, error_code, bad_count, e, exp_bad);
    end
  endtask

  task automatic test_done_hold();
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (rec_valid !== 1'b1 || format_type !== 2'b01 || rec_data !== 32'h0000abcd) begin
      errors++;
      $display("[TB] FAIL done_hold: got valid=%0d fmt=%0d data=%0h expected 1 1 abcd", rec_valid, format_type, rec_data);
    end
    send_char("x", 0);
    checks++;
    if (rec_valid !== 1'b0 || format_type !== 2'b00 || rec_time !== 16'd10 || rec_count !== 16'(exp_rec)) begin
      errors++;
      $display("[TB] FAIL done_leave: got valid=%0d fmt=%0d time=%0d rec=%0d expected 0 0 10 %0d", rec_valid, format_type, rec_time, rec_count, exp_rec);
    end
  endtask

  task automatic test_random(input int n);
    for (int it = 0; it < n; it++) begin
      string s;
      bit is_mem;
      int tdig, pcdig;
      longint tval, pcv, addrv, regv, datav;
      logic [3:0] e;
      is_mem = 1'($urandom_range(0, 1));
      tdig   = $urandom_range(1, 5);
      pcdig  = ($urandom_range(0, 7) == 0) ? 7 : 8;
      s = ($urandom_range(0, 3) == 0) ? "zq" : "";
      s = {s, "^"};
      tval = 0;
      for (int d = 0; d < tdig; d++) begin
        int dig;
        dig  = $urandom_range(0, 9);
        tval = tval * 10 + dig;
        s    = {s, $sformatf("%0d", dig)};
      end
      pcv = $urandom_range('h2FF0, 'h7010);
      if ($urandom_range(0, 1) == 1) pcv = pcv & ~longint'(3);
      s = {s, "@", (pcdig == 8) ? $sformatf("%08x", pcv) : $sformatf("%07x", pcv), ":", spaces($urandom_range(0, 2))};
      addrv = 0;
      regv  = 0;
      if (is_mem) begin
        addrv = $urandom_range(0, 'h3010);
        if ($urandom_range(0, 1) == 1) addrv = addrv & ~longint'(3);
        s = {s, "*", $sformatf("%08x", addrv)};
      end else begin
        regv = $urandom_range(0, 40);
        s = {s, "$", $sformatf("%0d", regv)};
      end
      datav = $urandom;
      s = {s, spaces($urandom_range(0, 2)), "<=", spaces($urandom_range(0, 2)), $sformatf("%08x", datav), "#"};
      send_line(s, -1);
      if (tdig <= 4 && pcdig == 8) begin
        e = model_err(is_mem, pcv, addrv, regv);
        model_accept(e);
        checks++;
        if (format_type !== (is_mem ? 2'b10 : 2'b01) || rec_time !== 16'(tval) || rec_pc !== 32'(pcv) || rec_data !== 32'(datav)) begin
          errors++;
          $display("[TB] FAIL rand_%0d_fields: got fmt=%0d time=%0d pc=%0h data=%0h expected mem=%0d %0d %0h %0h", it, format_type, rec_time, rec_pc, rec_data, is_mem, tval, pcv, datav);
        end
        checks++;
        if ((is_mem && rec_addr !== 32'(addrv)) || (!is_mem && rec_reg !== 5'(regv))) begin
          errors++;
          $display("[TB] FAIL rand_%0d_operand: got addr=%0h reg=%0d expected %0h %0d", it, rec_addr, rec_reg, addrv, regv % 32);
        end
        checks++;
        if (error_code !== e || rec_count !== 16'(exp_rec) || bad_count !== 16'(exp_bad)) begin
          errors++;
          $display("[TB] FAIL rand_%0d_status: got err=%b rec=%0d bad=%0d expected %b %0d %0d", it, error_code, rec_count, bad_count, e, exp_rec, exp_bad);
        end
      end else begin
        checks++;
        if (format_type !== 2'b00 || rec_valid !== 1'b0 || rec_count !== 16'(exp_rec)) begin
          errors++;
          $display("[TB] FAIL rand_%0d_reject: got fmt=%0d valid=%0d rec=%0d expected 0 0 %0d", it, format_type, rec_valid, rec_count, exp_rec);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    send_line("^3@00003000: $4 <= 1234", 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_rec = 0;
    exp_bad = 0;
    checks++;
    if (state_dbg !== 4'd0 || format_type !== 2'b00 || rec_count !== 16'd0 || bad_count !== 16'd0 ||
        {rec_time, rec_pc, rec_reg, rec_addr, rec_data, error_code} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got state=%0d fmt=%0d rec=%0d bad=%0d pc=%0h data=%0h expected all 0", state_dbg, format_type, rec_count, bad_count, rec_pc, rec_data);
    end
    send_line("5678#", 0);
    checks++;
    if (format_type !== 2'b00 || rec_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_discard: got fmt=%0d rec=%0d expected 0 0", format_type, rec_count);
    end
  endtask

  // Test sequence
  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_reg_record(0, "reg");
    test_mem_record();
    test_overflow();
    test_resync();
    test_semantic();
    test_reg_record(2, "gap");
    test_done_hold();
    test_random(40);
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
